// File: rtl/bus_latch_sequencer_pkg.sv
// Shared types and defaults for the tri-state latch bank sequencer.
// State encoding is fixed so that debug tools and checkers can decode it.
package bus_latch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_TURN  = 2'd3
  } state_e;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_DRIVE_CYC = 2;

  // One-hot to binary index; callers never have more than one bit set.
  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = oh[i] ? (idx | 3'(i)) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_latch_sequencer_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward
// from ptr+1 (mod NREQ), returned one-hot, plus an any-request flag.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic            any
);

  logic [PW:0]     sh_s;
  logic [NREQ-1:0] rot_s;
  logic [NREQ-1:0] pick_s;

  // Rotate so the highest-priority requester sits at bit 0, isolate the
  // lowest set bit, then rotate the pick back into place.
  always_comb begin
    if (ptr == PW'(NREQ - 1)) begin
      sh_s = '0;
    end else begin
      sh_s = {1'b0, ptr} + (PW + 1)'(1);
    end
    rot_s  = NREQ'({req, req} >> sh_s);
    pick_s = rot_s & (~rot_s + NREQ'(1));
    win    = NREQ'(({pick_s, pick_s} << sh_s) >> NREQ);
    any    = |req;
  end

endmodule

// File: rtl/bus_latch_sequencer.sv
// Sequences a bank of transparent latches sharing one tri-state bus:
// arbitrate, open/close the winner's latch, drive for DRIVE_CYC, acknowledge.
module bus_latch_sequencer
  import bus_latch_sequencer_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int DRIVE_CYC = DEF_DRIVE_CYC
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [NREQ-1:0] REQ,
  output logic [NREQ-1:0] HOLD_N,
  output logic [NREQ-1:0] OENB_N,
  output logic [NREQ-1:0] GNT,
  output logic            BUS_STB,
  output logic [NREQ-1:0] ACK,
  output logic            BUSY
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(DRIVE_CYC) + 1;
  localparam logic [PW-1:0] PTR_RST  = PW'(NREQ - 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DRIVE_CYC - 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] hold_n_q, hold_n_d;
  logic [NREQ-1:0] oenb_n_q, oenb_n_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            bus_stb_q, bus_stb_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] win_s;
  logic            any_s;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req (REQ),
    .ptr (ptr_q),
    .win (win_s),
    .any (any_s)
  );

  // Next-state and next-output logic; latch controls default to hold/Z so
  // only the state that needs a latch open or driving ever asserts it.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    hold_n_d  = '0;
    oenb_n_d  = '1;
    ack_d     = '0;
    bus_stb_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_s) begin
          state_d  = ST_LOAD;
          gnt_d    = win_s;
          hold_n_d = win_s;
          ptr_d    = PW'(oh2idx(8'(win_s)));
        end else begin
          gnt_d = '0;
        end
      end
      ST_LOAD: begin
        state_d   = ST_DRIVE;
        oenb_n_d  = ~gnt_q;
        cnt_d     = CNT_LOAD;
        bus_stb_d = (CNT_LOAD == '0);
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          state_d = ST_TURN;
          gnt_d   = '0;
          ack_d   = gnt_q;
        end else begin
          cnt_d     = cnt_q - CW'(1);
          oenb_n_d  = ~gnt_q;
          bus_stb_d = (cnt_q == CW'(1));
        end
      end
      ST_TURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset parks every latch in hold with Z outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      ptr_q     <= PTR_RST;
      cnt_q     <= '0;
      gnt_q     <= '0;
      hold_n_q  <= '0;
      oenb_n_q  <= '1;
      ack_q     <= '0;
      bus_stb_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      hold_n_q  <= hold_n_d;
      oenb_n_q  <= oenb_n_d;
      ack_q     <= ack_d;
      bus_stb_q <= bus_stb_d;
      busy_q    <= busy_d;
    end
  end

  assign HOLD_N  = hold_n_q;
  assign OENB_N  = oenb_n_q;
  assign GNT     = gnt_q;
  assign ACK     = ack_q;
  assign BUS_STB = bus_stb_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_bus_latch_sequencer.sv
// Directed bench: DRIVE_CYC=2 instance for the main sequence, DRIVE_CYC=1
// instance for the single-drive-cycle case; bus invariants checked each cycle.
module tb_bus_latch_sequencer;

  logic       CLK;
  logic       RESET;
  logic [3:0] REQ,    REQ_B;
  logic [3:0] HOLD_N, HOLD_N_B;
  logic [3:0] OENB_N, OENB_N_B;
  logic [3:0] GNT,    GNT_B;
  logic [3:0] ACK,    ACK_B;
  logic       BUS_STB, BUS_STB_B;
  logic       BUSY,    BUSY_B;

  int total;
  int bad;

  bus_latch_sequencer #(.NREQ(4), .DRIVE_CYC(2)) u_dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .REQ     (REQ),
    .HOLD_N  (HOLD_N),
    .OENB_N  (OENB_N),
    .GNT     (GNT),
    .BUS_STB (BUS_STB),
    .ACK     (ACK),
    .BUSY    (BUSY)
  );

  bus_latch_sequencer #(.NREQ(4), .DRIVE_CYC(1)) u_dut_b (
    .CLK     (CLK),
    .RESET   (RESET),
    .REQ     (REQ_B),
    .HOLD_N  (HOLD_N_B),
    .OENB_N  (OENB_N_B),
    .GNT     (GNT_B),
    .BUS_STB (BUS_STB_B),
    .ACK     (ACK_B),
    .BUSY    (BUSY_B)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One full DRIVE_CYC=2 grant on u_dut, starting from IDLE with REQ set.
  task automatic txn2(input logic [3:0] w, input bit drop_in_load);
    tick();
    chk4("load_gnt", GNT, w);
    chk4("load_hold", HOLD_N, w);
    chk4("load_oenb", OENB_N, 4'b1111);
    chk4("load_ack", ACK, 4'b0000);
    chk1("load_busy", BUSY, 1'b1);
    chk1("load_stb", BUS_STB, 1'b0);
    if (drop_in_load) REQ = 4'b0000;
    tick();
    chk4("drv1_gnt", GNT, w);
    chk4("drv1_hold", HOLD_N, 4'b0000);
    chk4("drv1_oenb", OENB_N, ~w);
    chk1("drv1_stb", BUS_STB, 1'b0);
    tick();
    chk4("drv2_oenb", OENB_N, ~w);
    chk1("drv2_stb", BUS_STB, 1'b1);
    chk4("drv2_ack", ACK, 4'b0000);
    tick();
    chk4("turn_oenb", OENB_N, 4'b1111);
    chk4("turn_gnt", GNT, 4'b0000);
    chk4("turn_ack", ACK, w);
    chk1("turn_stb", BUS_STB, 1'b0);
    chk1("turn_busy", BUSY, 1'b1);
    tick();
    chk4("idle_ack", ACK, 4'b0000);
    chk4("idle_gnt", GNT, 4'b0000);
    chk1("idle_busy", BUSY, 1'b0);
  endtask

  // Bus invariants on both instances, sampled mid-cycle.
  always @(negedge CLK) begin
    if (!RESET) begin
      chk1("inv_oenb_1hot", $onehot0(~OENB_N), 1'b1);
      chk1("inv_hold_1hot", $onehot0(HOLD_N), 1'b1);
      chk1("inv_gnt_1hot", $onehot0(GNT), 1'b1);
      chk4("inv_drive_open", ~OENB_N & HOLD_N, 4'b0000);
      chk1("inv_b_oenb_1hot", $onehot0(~OENB_N_B), 1'b1);
      chk1("inv_b_hold_1hot", $onehot0(HOLD_N_B), 1'b1);
      chk4("inv_b_drive_open", ~OENB_N_B & HOLD_N_B, 4'b0000);
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    RESET = 1'b1;
    REQ   = 4'b1111;
    REQ_B = 4'b1111;

    // Reset held with all requests high: outputs stay at reset values.
    tick();
    tick();
    chk4("rst_hold", HOLD_N, 4'b0000);
    chk4("rst_oenb", OENB_N, 4'b1111);
    chk4("rst_gnt", GNT, 4'b0000);
    chk4("rst_ack", ACK, 4'b0000);
    chk1("rst_stb", BUS_STB, 1'b0);
    chk1("rst_busy", BUSY, 1'b0);
    chk4("rst_b_oenb", OENB_N_B, 4'b1111);
    chk1("rst_b_busy", BUSY_B, 1'b0);
    REQ_B = 4'b0000;
    RESET = 1'b0;

    // All four requesting: rotation 0,1,2,3,0 with 5-cycle spacing.
    txn2(4'b0001, 1'b0);
    txn2(4'b0010, 1'b0);
    txn2(4'b0100, 1'b0);
    txn2(4'b1000, 1'b0);
    txn2(4'b0001, 1'b0);
    REQ = 4'b0000;
    tick();
    chk1("quiet_busy", BUSY, 1'b0);
    chk4("quiet_gnt", GNT, 4'b0000);

    // Single request on latch 2.
    REQ = 4'b0100;
    txn2(4'b0100, 1'b0);

    // Fairness: 0 held, 3 raised while 0 is served.
    REQ = 4'b0001;
    txn2(4'b0001, 1'b0);
    REQ = 4'b1001;
    txn2(4'b1000, 1'b0);
    REQ = 4'b0001;
    txn2(4'b0001, 1'b0);

    // REQ[1] dropped during LOAD still completes.
    REQ = 4'b0010;
    txn2(4'b0010, 1'b1);
    tick();
    chk1("drop_idle_busy", BUSY, 1'b0);
    chk4("drop_idle_gnt", GNT, 4'b0000);

    // Asynchronous reset in the middle of DRIVE.
    REQ = 4'b0100;
    tick();
    chk4("mid_load_gnt", GNT, 4'b0100);
    tick();
    chk4("mid_drv_oenb", OENB_N, 4'b1011);
    #2;
    RESET = 1'b1;
    #1;
    chk4("arst_oenb", OENB_N, 4'b1111);
    chk4("arst_gnt", GNT, 4'b0000);
    chk4("arst_hold", HOLD_N, 4'b0000);
    chk1("arst_busy", BUSY, 1'b0);
    REQ = 4'b0000;
    tick();
    chk4("arst_ack_a", ACK, 4'b0000);
    RESET = 1'b0;
    tick();
    chk4("arst_ack_b", ACK, 4'b0000);
    chk1("arst_idle", BUSY, 1'b0);

    // Pointer restored by reset: index 0 scans first, so 1 beats 2.
    REQ = 4'b0110;
    txn2(4'b0010, 1'b0);
    REQ = 4'b0000;

    // Single DRIVE cycle build: strobe with the only DRIVE cycle, ACK third cycle.
    REQ_B = 4'b0100;
    tick();
    chk4("b_load_gnt", GNT_B, 4'b0100);
    chk4("b_load_hold", HOLD_N_B, 4'b0100);
    chk1("b_load_stb", BUS_STB_B, 1'b0);
    REQ_B = 4'b0000;
    tick();
    chk4("b_drv_oenb", OENB_N_B, 4'b1011);
    chk1("b_drv_stb", BUS_STB_B, 1'b1);
    chk4("b_drv_ack", ACK_B, 4'b0000);
    tick();
    chk4("b_turn_ack", ACK_B, 4'b0100);
    chk4("b_turn_oenb", OENB_N_B, 4'b1111);
    chk1("b_turn_stb", BUS_STB_B, 1'b0);
    tick();
    chk4("b_idle_ack", ACK_B, 4'b0000);
    chk1("b_idle_busy", BUSY_B, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
